// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 responder giving a master single-word read/write
// access to a word buffer through a request/acknowledge port.
// The SPI pins are oversampled in the CLK_I domain.
// Write frame: command byte, then DATA_W data bits.
// Read frame:  command byte, a dummy byte, then DATA_W data bits on MISO.
module spi_slave_regs #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    input  logic              SPI_CLK,
    input  logic              SPI_CS_N,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic [ADDR_W-1:0] BUF_ADDR_O,
    output logic [DATA_W-1:0] BUF_DATA_O,
    input  logic [DATA_W-1:0] BUF_DATA_I,
    output logic              BUF_WE_O,
    output logic              BUF_REQ_O,
    input  logic              BUF_ACK_I,
    output logic              FRAME_ERR_O
);

    // Counter value seen when the last bit of each phase is being sampled.
    localparam logic [5:0] CMD_LAST   = 6'd7;
    localparam logic [5:0] DUMMY_LAST = 6'd15;
    localparam logic [5:0] RD_LAST    = 6'(16 + DATA_W - 1);
    localparam logic [5:0] WR_LAST    = 6'(8 + DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_RD_DUMMY = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_WR_DATA  = 3'd4,
        ST_WR_REQ   = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_prev_r;
    logic                   cs_prev_r;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic sample_s;
    logic ack_s;
    logic rd_trig_s;
    logic wr_trig_s;
    logic [ADDR_W-1:0] cmd_addr_s;

    state_t            state_r;
    logic [5:0]        bit_cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] rd_shift_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic              rd_pend_r;   // read wanted but a prior request still occupies the port
    logic              rd_want_r;   // this frame still wants read data from the next ACK
    logic              rd_got_r;    // read data arrived in time for this frame
    logic              wr_pend_r;   // write wanted but a prior request still occupies the port
    logic              wr_out_r;    // this frame's write request is outstanding
    logic              req_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              miso_r;
    logic              err_r;

    assign sck_s  = sck_sync_r[SYNC_STAGES-1];
    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;
    assign cs_rise_s  = cs_s & ~cs_prev_r;
    assign cs_fall_s  = ~cs_s & cs_prev_r;

    // A chip-select rise takes precedence over a clock edge in the same cycle.
    assign sample_s   = sck_rise_s & ~cs_rise_s;
    assign ack_s      = req_r & BUF_ACK_I;
    assign cmd_addr_s = {shift_r[ADDR_W-2:0], mosi_s};

    assign rd_trig_s = (state_r == ST_CMD) && sample_s && (bit_cnt_r == CMD_LAST) && !shift_r[6];
    assign wr_trig_s = (state_r == ST_WR_DATA) && sample_s && (bit_cnt_r == WR_LAST);

    // Synchronize the SPI pins and keep the previous level for edge detection.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_prev_r  <= 1'b0;
            cs_prev_r   <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], SPI_MOSI};
            sck_prev_r  <= sck_s;
            cs_prev_r   <= cs_s;
        end
    end

    // Frame FSM, shift registers and buffer request engine.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 6'd0;
            shift_r    <= {DATA_W{1'b0}};
            rd_shift_r <= {DATA_W{1'b0}};
            cmd_addr_r <= {ADDR_W{1'b0}};
            rd_pend_r  <= 1'b0;
            rd_want_r  <= 1'b0;
            rd_got_r   <= 1'b0;
            wr_pend_r  <= 1'b0;
            wr_out_r   <= 1'b0;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            miso_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            err_r <= 1'b0;

            // Request engine: one access at a time; REQ drops the cycle after ACK.
            if (ack_s) begin
                req_r    <= 1'b0;
                wr_out_r <= 1'b0;
                // An ACK seen while our read is still queued belongs to an older request.
                if (rd_want_r && !rd_pend_r) begin
                    rd_shift_r <= BUF_DATA_I;
                    rd_got_r   <= 1'b1;
                    rd_want_r  <= 1'b0;
                end
            end else if (!req_r) begin
                if (rd_trig_s) begin
                    req_r  <= 1'b1;
                    we_r   <= 1'b0;
                    addr_r <= cmd_addr_s;
                end else if (rd_pend_r) begin
                    req_r     <= 1'b1;
                    we_r      <= 1'b0;
                    addr_r    <= cmd_addr_r;
                    rd_pend_r <= 1'b0;
                end else if (wr_trig_s) begin
                    req_r    <= 1'b1;
                    we_r     <= 1'b1;
                    addr_r   <= cmd_addr_r;
                    wdata_r  <= {shift_r[DATA_W-2:0], mosi_s};
                    wr_out_r <= 1'b1;
                end else if (wr_pend_r) begin
                    req_r     <= 1'b1;
                    we_r      <= 1'b1;
                    addr_r    <= cmd_addr_r;
                    wdata_r   <= shift_r;
                    wr_out_r  <= 1'b1;
                    wr_pend_r <= 1'b0;
                end
            end

            if (rd_trig_s) begin
                rd_want_r <= 1'b1;
                if (req_r) begin
                    rd_pend_r <= 1'b1;
                end
            end
            if (wr_trig_s && req_r) begin
                wr_pend_r <= 1'b1;
            end

            // Frame sequencing; assignments here override the engine on abort/timeout.
            case (state_r)
                ST_IDLE: begin
                    miso_r <= 1'b0;
                    if (cs_fall_s) begin
                        state_r    <= ST_CMD;
                        bit_cnt_r  <= 6'd0;
                        shift_r    <= {DATA_W{1'b0}};
                        rd_shift_r <= {DATA_W{1'b0}};
                        rd_got_r   <= 1'b0;
                    end
                end
                ST_CMD: begin
                    miso_r <= 1'b0;
                    if (cs_rise_s) begin
                        state_r   <= ST_IDLE;
                        err_r     <= 1'b1;
                        rd_pend_r <= 1'b0;
                        rd_want_r <= 1'b0;
                    end else if (sck_rise_s) begin
                        shift_r   <= {shift_r[DATA_W-2:0], mosi_s};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                        if (bit_cnt_r == CMD_LAST) begin
                            cmd_addr_r <= cmd_addr_s;
                            state_r    <= shift_r[6] ? ST_WR_DATA : ST_RD_DUMMY;
                        end
                    end
                end
                ST_RD_DUMMY: begin
                    miso_r <= 1'b0;
                    if (cs_rise_s) begin
                        state_r   <= ST_IDLE;
                        err_r     <= 1'b1;
                        rd_pend_r <= 1'b0;
                        rd_want_r <= 1'b0;
                    end else if (sck_rise_s) begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                        if (bit_cnt_r == DUMMY_LAST) begin
                            state_r <= ST_RD_DATA;
                            // Data not in hand: send zeros and discard whatever arrives later.
                            if (!rd_got_r) begin
                                err_r      <= 1'b1;
                                rd_want_r  <= 1'b0;
                                rd_shift_r <= {DATA_W{1'b0}};
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (cs_rise_s) begin
                        state_r   <= ST_IDLE;
                        err_r     <= 1'b1;
                        miso_r    <= 1'b0;
                        rd_pend_r <= 1'b0;
                        rd_want_r <= 1'b0;
                    end else if (sck_rise_s) begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                        if (bit_cnt_r == RD_LAST) begin
                            state_r <= ST_DONE;
                            miso_r  <= 1'b0;
                        end
                    end else if (sck_fall_s) begin
                        miso_r     <= rd_shift_r[DATA_W-1];
                        rd_shift_r <= {rd_shift_r[DATA_W-2:0], 1'b0};
                    end
                end
                ST_WR_DATA: begin
                    miso_r <= 1'b0;
                    if (cs_rise_s) begin
                        state_r <= ST_IDLE;
                        err_r   <= 1'b1;
                    end else if (sck_rise_s) begin
                        shift_r   <= {shift_r[DATA_W-2:0], mosi_s};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                        if (bit_cnt_r == WR_LAST) begin
                            state_r <= ST_WR_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    miso_r <= 1'b0;
                    // Chip select may already be high; the write still completes.
                    if (ack_s && wr_out_r) begin
                        state_r <= cs_s ? ST_IDLE : ST_DONE;
                    end
                end
                ST_DONE: begin
                    miso_r <= 1'b0;
                    if (cs_rise_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

    assign SPI_MISO    = miso_r;
    assign BUF_ADDR_O  = addr_r;
    assign BUF_DATA_O  = wdata_r;
    assign BUF_WE_O    = we_r;
    assign BUF_REQ_O   = req_r;
    assign FRAME_ERR_O = err_r;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: SPI master tasks, an auto-ACK buffer
// responder and a request/error monitor; expected values are hand-computed.
module tb_spi_slave_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [6:0]  buf_addr;
    logic [31:0] buf_data_o;
    logic [31:0] buf_data = 32'h0;
    logic        buf_we;
    logic        buf_req;
    logic        buf_ack;
    logic        frame_err;

    logic        man_ack  = 1'b0;
    logic        auto_ack = 1'b0;
    logic        ack_en   = 1'b0;
    int          ack_delay = 3;
    int          req_age   = 0;

    int          req_cnt  = 0;
    int          err_cnt  = 0;
    int          unst_cnt = 0;
    logic        req_q    = 1'b0;
    logic [6:0]  cap_addr = 7'h0;
    logic        cap_we   = 1'b0;
    logic [31:0] cap_data = 32'h0;

    int          n_vec = 0;
    int          n_err = 0;
    int          base_req;
    int          base_err;
    int          base_unst;
    logic [47:0] rx_buf;
    logic [47:0] tx;

    assign buf_ack = auto_ack | man_ack;

    always #5 clk = ~clk;

    spi_slave_regs dut (
        .CLK_I       (clk),
        .RST_N_I     (rst_n),
        .SPI_CLK     (spi_clk),
        .SPI_CS_N    (spi_cs_n),
        .SPI_MOSI    (spi_mosi),
        .SPI_MISO    (spi_miso),
        .BUF_ADDR_O  (buf_addr),
        .BUF_DATA_O  (buf_data_o),
        .BUF_DATA_I  (buf_data),
        .BUF_WE_O    (buf_we),
        .BUF_REQ_O   (buf_req),
        .BUF_ACK_I   (buf_ack),
        .FRAME_ERR_O (frame_err)
    );

    // Buffer responder: one-cycle ACK a fixed number of cycles after REQ rises.
    always @(negedge clk) begin
        if (auto_ack) auto_ack = 1'b0;
        else if (ack_en && buf_req && req_age == ack_delay) auto_ack = 1'b1;
        if (buf_req) req_age = req_age + 1;
        else req_age = 0;
    end

    // Monitor: count requests and error pulses, capture request fields, watch stability.
    always @(negedge clk) begin
        if (buf_req && !req_q) begin
            req_cnt  = req_cnt + 1;
            cap_addr = buf_addr;
            cap_we   = buf_we;
            cap_data = buf_data_o;
        end else if (buf_req && req_q &&
                     (buf_addr !== cap_addr || buf_we !== cap_we || buf_data_o !== cap_data)) begin
            unst_cnt = unst_cnt + 1;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        req_q = buf_req;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snapshot;
        base_req  = req_cnt;
        base_err  = err_cnt;
        base_unst = unst_cnt;
    endtask

    task automatic frame_begin;
        rx_buf   = 48'h0;
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end;
        tick(4);
        spi_cs_n = 1'b1;
        tick(12);
    endtask

    // Send bits [from, upto) of a left-aligned 48-bit frame, capturing MISO before each rise.
    task automatic xfer(input logic [47:0] t, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            spi_mosi = t[47-i];
            tick(4);
            rx_buf[47-i] = spi_miso;
            spi_clk = 1'b1;
            tick(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic pulse_ack(input logic [31:0] d);
        buf_data = d;
        man_ack  = 1'b1;
        tick(1);
        man_ack  = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [6:0] a, input logic [31:0] d);
        check({tag, "_req_count"}, 64'(req_cnt - base_req), 64'd1);
        check({tag, "_we"}, 64'(cap_we), 64'd1);
        check({tag, "_addr"}, 64'(cap_addr), 64'(a));
        check({tag, "_data"}, 64'(cap_data), 64'(d));
        check({tag, "_err"}, 64'(err_cnt - base_err), 64'd0);
        check({tag, "_stable"}, 64'(unst_cnt - base_unst), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(5);
        check("reset_outputs", 64'({buf_req, buf_we, spi_miso, frame_err, buf_addr, buf_data_o}), 64'd0);
        rst_n = 1'b1;
        tick(5);
        check("idle_outputs", 64'({buf_req, buf_we, spi_miso, frame_err, buf_addr, buf_data_o}), 64'd0);

        // Write 0x12345678 to address 5.
        ack_en = 1'b1;
        snapshot();
        tx = {8'h85, 32'h12345678, 8'h00};
        frame_begin(); xfer(tx, 0, 40); frame_end();
        check_write("write", 7'h05, 32'h12345678);
        check("write_miso", 64'(rx_buf), 64'd0);
        check("write_req_low", 64'(buf_req), 64'd0);

        // Read address 5, ACK with 0xCAFEF00D.
        snapshot();
        buf_data = 32'hCAFEF00D;
        tx = {8'h05, 8'h00, 32'h0};
        frame_begin(); xfer(tx, 0, 48); frame_end();
        check("read_req_count", 64'(req_cnt - base_req), 64'd1);
        check("read_we", 64'(cap_we), 64'd0);
        check("read_addr", 64'(cap_addr), 64'h05);
        check("read_miso_data", 64'(rx_buf[31:0]), 64'hCAFEF00D);
        check("read_miso_hdr", 64'(rx_buf[47:32]), 64'd0);
        check("read_err", 64'(err_cnt - base_err), 64'd0);

        // Read timeout: ACK withheld until after bit 16; late data discarded.
        ack_en = 1'b0;
        snapshot();
        tx = {8'h0A, 8'h00, 32'h0};
        frame_begin(); xfer(tx, 0, 20);
        check("tmo_err_pulse", 64'(err_cnt - base_err), 64'd1);
        check("tmo_req_held", 64'(buf_req), 64'd1);
        check("tmo_addr", 64'(cap_addr), 64'h0A);
        pulse_ack(32'hFFFFFFFF);
        tick(1);
        check("tmo_req_drop", 64'(buf_req), 64'd0);
        xfer(tx, 20, 48); frame_end();
        check("tmo_miso_zero", 64'(rx_buf), 64'd0);
        check("tmo_err_once", 64'(err_cnt - base_err), 64'd1);
        check("tmo_req_count", 64'(req_cnt - base_req), 64'd1);

        // Abort a write after 20 bits, then a clean write.
        ack_en = 1'b1;
        snapshot();
        tx = {8'h85, 32'hAAAAAAAA, 8'h00};
        frame_begin(); xfer(tx, 0, 20); frame_end();
        check("abort_no_req", 64'(req_cnt - base_req), 64'd0);
        check("abort_err", 64'(err_cnt - base_err), 64'd1);
        snapshot();
        tx = {8'h83, 32'h0BADBEEF, 8'h00};
        frame_begin(); xfer(tx, 0, 40); frame_end();
        check_write("after_abort", 7'h03, 32'h0BADBEEF);

        // Overrun: 48 clocks in a write frame produce exactly one write.
        snapshot();
        tx = {8'h86, 32'hDEADBEEF, 8'hFF};
        frame_begin(); xfer(tx, 0, 48); frame_end();
        check_write("overrun", 7'h06, 32'hDEADBEEF);

        // CS_N rises while the write waits for ACK; the write still completes.
        ack_en = 1'b0;
        snapshot();
        tx = {8'h87, 32'h55AA33CC, 8'h00};
        frame_begin(); xfer(tx, 0, 40); frame_end();
        check("wrreq_req_held", 64'(buf_req), 64'd1);
        pulse_ack(32'h0);
        tick(1);
        check("wrreq_req_drop", 64'(buf_req), 64'd0);
        check_write("wrreq", 7'h07, 32'h55AA33CC);

        // Asynchronous reset in the middle of a read with its request outstanding.
        tx = {8'h09, 8'h00, 32'h0};
        frame_begin(); xfer(tx, 0, 12);
        check("rst_pre_req", 64'(buf_req), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", 64'({buf_req, buf_we, spi_miso, frame_err, buf_addr, buf_data_o}), 64'd0);
        spi_cs_n = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        ack_en = 1'b1;
        snapshot();
        tx = {8'h81, 32'hFFFFFFFF, 8'h00};
        frame_begin(); xfer(tx, 0, 40); frame_end();
        check_write("post_reset", 7'h01, 32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI responder (mode 0) that gives an external SPI master read/write access to a 32-bit word buffer over the serial interface. It is the far end of the SPI link driven by the SPI_MASTER: the same command/data framing, seen from the target side. It oversamples SPI_CLK, SPI_CS_N and SPI_MOSI in the CLK_I domain, decodes command frames, and performs single-word transfers on a request/acknowledge buffer port.

## Interface
- DATA_W, 32: buffer word width and data-phase bit count.
- ADDR_W, 7: buffer address width, taken from the command byte.
- SYNC_STAGES, 2: flip-flop stages on each SPI input.

- CLK_I, in, 1: system clock; all logic on its rising edge.
- RST_N_I, in, 1: reset, asynchronous, active-low.
- SPI_CLK, in, 1: serial clock from the master, idle low.
- SPI_CS_N, in, 1: chip select, active low; frames the transfer.
- SPI_MOSI, in, 1: serial data from the master, MSB first.
- SPI_MISO, out, 1: serial data to the master, MSB first. Driven 0 when not shifting read data (no tristate).
- BUF_ADDR_O, out, ADDR_W: buffer word address.
- BUF_DATA_O, out, DATA_W: write data.
- BUF_DATA_I, in, DATA_W: read data, valid when BUF_ACK_I is high.
- BUF_WE_O, out, 1: 1 = write, 0 = read; valid while BUF_REQ_O is high.
- BUF_REQ_O, out, 1: access request; held until BUF_ACK_I.
- BUF_ACK_I, in, 1: single-cycle access completion.
- FRAME_ERR_O, out, 1: one-cycle pulse on a framing or read-timeout error.

## Operation
- Inputs pass through SYNC_STAGES flip-flops, then edge detection (rise and fall of SPI_CLK, fall and rise of SPI_CS_N).
- SPI_MOSI is sampled on detected SPI_CLK rise. SPI_MISO updates on detected SPI_CLK fall.
- **Command byte (8 bits):**
  - bit7 = R/W (1 = write).
  - bits6:0 = address.
- **Write frame (40 bits):** command, then DATA_W data bits. After bit 40 the block raises BUF_REQ_O with BUF_WE_O = 1.
- **Read frame (48 bits):** command, then 8 dummy bits, then DATA_W data bits.
  - BUF_REQ_O with BUF_WE_O = 0 is raised on the cycle after bit 8 is sampled.
  - Data latches on BUF_ACK_I.
  - MISO is 0 during the command and dummy bytes.
- **States:**
  - IDLE: CS_N fall → CMD.
  - CMD: after 8 bits → RD_DUMMY (R/W = 0) or WR_DATA (R/W = 1).
  - RD_DUMMY: after 8 bits → RD_DATA.
  - RD_DATA: after DATA_W bits → DONE.
  - WR_DATA: after DATA_W bits → WR_REQ.
  - WR_REQ: on ACK → DONE.
  - DONE: ignores further SPI_CLK edges, MISO = 0; CS_N rise → IDLE.
- **Bit counter:** 6 bits; cleared on CS_N fall.
- **Read timeout:** if BUF_ACK_I has not arrived when bit 16 is sampled, shift out all zeros for the data phase and pulse FRAME_ERR_O. The outstanding request is still held until ACK, and the late data is discarded.
- **CS_N rise before the frame completes:** abort to IDLE, no buffer write, pulse FRAME_ERR_O. A pending read request is held until ACK, then dropped.
- **CS_N rise while in WR_REQ:** not an abort; the write completes.
- **CS_N fall while a request from a prior frame is still pending:** the new command is decoded normally, and its request is issued only after the pending ACK.
- **Reset values:**
  - All outputs 0.
  - State IDLE.
  - Shift registers and counter 0.
  - Synchronizers reset to idle levels (CS_N stage = 1, SCK = 0).
  - Reset mid-frame discards everything; no request is issued.

## Timing
- Detected-edge latency: SYNC_STAGES + 1 CLK_I cycles after the pin edge.
- **Master constraints:**
  - SPI_CLK high and low each ≥ 4 CLK_I cycles.
  - CS_N fall to first SCK rise ≥ 4 CLK_I cycles.
  - Last SCK fall to CS_N rise ≥ 4 CLK_I cycles.
- **SPI_MISO:** registered, updates 1 CLK_I cycle after the detected fall. The data MSB is driven after the fall following bit 16.
- **Read data register:** loaded from BUF_DATA_I in the ACK cycle. Must hold valid data before the bit-16 sample, i.e. ACK within 8 SCK periods of the request.
- **BUF_REQ_O:** asserted 1 cycle after the triggering sample; deasserted the cycle after ACK is seen. BUF_ADDR_O, BUF_DATA_O and BUF_WE_O are stable throughout.
- **ACK handling:** ACK arriving with REQ low is ignored.

## Test plan
- **Write:** frame 0x85, 0x12345678, SCK = CLK_I/8 → one request, WE = 1, ADDR = 0x05, DATA = 0x12345678; no FRAME_ERR_O.
- **Read:** frame 0x05, dummy, 32 clocks; ACK 3 cycles after REQ with 0xCAFEF00D → MISO bits 16..47 = 0xCAFEF00D MSB first; WE = 0, ADDR = 0x05.
- **Read timeout:** as above but ACK withheld until after bit 16 → MISO data all 0; one FRAME_ERR_O pulse; REQ held until ACK.
- **Abort:** CS_N rises after 20 bits of a write → no request, FRAME_ERR_O pulses once, state IDLE; the next valid frame succeeds.
- **Overrun and WR_REQ:**
  - 48 clocks in a write frame → exactly one write; extra bits ignored.
  - CS_N rises in WR_REQ → write still completes on ACK.
- **Async reset:** RST_N_I low mid-read → all outputs 0 immediately, REQ drops; after release, the frame 0x81, 0xFFFFFFFF writes address 1.
